seq_signed_divider: RTL
=======================

Name: seq_signed_divider

Overview:
Iterative two's-complement signed divider. It is the inverse companion of the team's shift-add multiplier and produces quotient and remainder with one restoring shift-subtract step per clock. It sits beside the multiplier in the arithmetic library and is driven by a start/done handshake from a control FSM.

Parameters:
WIDTH, 8, operand/result width in bits (>=2); all operands and results are signed two's complement.

Ports:
clk  input  1  rising-edge clock, single clock domain
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only while busy=0
dividend  input  WIDTH  signed dividend, captured on accepted start
divisor  input  WIDTH  signed divisor, captured on accepted start
busy  output  1  high while a division is in progress
done  output  1  one-cycle pulse: results valid and updated
quotient  output  WIDTH  signed quotient, held until next done
remainder  output  WIDTH  signed remainder, held until next done
div_by_zero  output  1  set with done when divisor was 0; held until next done

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; internal registers cleared. Applying rst mid-operation aborts the division. No done is produced for the aborted operation.
- States: IDLE, CALC, FIX.
- IDLE: if start=1 at edge k:
  - Capture |dividend|, |divisor| and both sign bits.
  - Set busy=1 and clear the iteration counter.
  - If divisor==0, go to FIX with the zero flag set. Otherwise go to CALC.
- CALC: one restoring step per edge, running from MSB to LSB:
  - rem = {rem[WIDTH-2:0], dvd_msb}.
  - If rem >= |divisor|: rem -= |divisor| and q_bit=1. Otherwise q_bit=0.
  - Unsigned magnitude arithmetic is WIDTH+1 bits wide, so |most-negative| = 2^(WIDTH-1) is representable.
  - After exactly WIDTH steps (counter wraps at WIDTH-1), go to FIX.
- FIX (one edge):
  - Apply the signs. Quotient is negated if the operand signs differ (truncation toward zero). Remainder takes the sign of the dividend.
  - Write quotient/remainder/div_by_zero. Pulse done=1 and drop busy=0. Return to IDLE.
- Latency, normal case: start accepted at edge k gives done=1 after edge k+WIDTH+1 (for WIDTH=8, 9 cycles). Divide-by-zero: done after edge k+1.
- Divide by zero: quotient = all ones (-1), remainder = dividend, div_by_zero=1.
- Overflow: most-negative / -1 gives quotient = most-negative (wraps) and remainder = 0. There is no flag and div_by_zero=0.
- Invariant for nonzero divisor: dividend == quotient*divisor + remainder (mod 2^WIDTH), |remainder| < |divisor|.
- start while busy=1 is ignored; operands are not re-sampled.
- start on the same cycle done=1 is accepted, since state is IDLE. Back-to-back throughput is one division per WIDTH+2 cycles.
- done is exactly one cycle wide. Outputs are stable between done pulses.

Decomposition:
- Shared package `divider_pkg`:
  - State enum (IDLE, CALC, FIX).
  - Default WIDTH.
  - Counter-width constant $clog2(WIDTH).
  - Helper functions abs_val and neg.
- Sub-module `div_step`: combinational single restoring iteration.
  - Inputs: rem, next dividend bit, divisor magnitude.
  - Outputs: new rem, q_bit.
  - Instantiated once inside the FSM.

Test Plan:
- WIDTH=8, dividend=100, divisor=7, start pulse at edge k -> busy=1 at edges k..k+8. At edge k+9: done=1, quotient=14 (0x0E), remainder=2, div_by_zero=0.
- dividend=-100 (0x9C), divisor=7 -> quotient=-14 (0xF2), remainder=-2 (0xFE). Also cover 100/-7 -> 0xF2/0x02 and -100/-7 -> 0x0E/0xFE.
- dividend=7, divisor=0 -> done after edge k+1, div_by_zero=1, quotient=0xFF, remainder=0x07. The next valid division (9/3) must clear div_by_zero and give 3/0.
- Boundary values:
  - dividend=-128, divisor=-1 -> quotient=0x80, remainder=0, div_by_zero=0.
  - -128/1 -> 0x80/0.
  - 127/-128 -> 0/127.
- Start during busy, then reset mid-operation:
  - A second start with different operands at edge k+3 -> ignored; the first result is unchanged.
  - Assert rst asynchronously at k+4 -> all outputs 0 immediately; no done pulse follows.
  - A new start after rst deasserts completes normally.
- Random sweep of 10k signed operand pairs against a reference model of truncating division. Also check back-to-back starts issued on the done cycle.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared types and magnitude helpers for the iterative signed divider.
// Helpers work on a 64-bit word; callers size-cast results back to their own width.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = $clog2(DEF_WIDTH);
    localparam int MAX_W     = 64;

    typedef logic [MAX_W-1:0] word_t;

    function automatic word_t neg(input word_t x);
        return ~x + word_t'(1);
    endfunction

    // Argument must already be sign-extended to MAX_W bits.
    function automatic word_t abs_val(input word_t x);
        return x[MAX_W-1] ? neg(x) : x;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes.
// Latency: combinational. Backpressure: none, purely combinational.
module div_step
    import divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] dsr,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] dsr_ext;

    assign shifted = {rem, dvd_bit};
    assign dsr_ext = {1'b0, dsr};
    assign q_bit   = (shifted >= dsr_ext);

    // rem stays below dsr, so the shifted value always fits back into WIDTH bits.
    always_comb begin
        rem_next = shifted[WIDTH-1:0];
        if (q_bit) begin
            rem_next = WIDTH'(shifted - dsr_ext);
        end
    end

endmodule

// File: rtl/seq_signed_divider.sv
// Iterative signed divider: truncating quotient, remainder with dividend sign.
// Latency: WIDTH+1 cycles from accepted start to done (1 cycle for divide by zero).
// Backpressure: start is ignored while busy; results held until the next done.
module seq_signed_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dsr_q, dsr_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               dvd_neg_q, dvd_neg_d;
    logic               dsr_neg_q, dsr_neg_d;
    logic               zero_q, zero_d;
    logic               busy_d, done_d, dbz_d;
    logic [WIDTH-1:0]   quot_d, remo_d;

    logic [WIDTH-1:0]   step_rem;
    logic               step_q;
    word_t              dvd_ext, dsr_ext;
    logic [WIDTH-1:0]   dvd_abs, dsr_abs;
    logic [WIDTH-1:0]   rem_mag, q_fix, r_fix;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .dvd_bit  (dvd_q[WIDTH-1]),
        .dsr      (dsr_q),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    // Magnitude of the most-negative value is 2^(WIDTH-1), which still fits unsigned.
    assign dvd_ext = word_t'(signed'(dividend));
    assign dsr_ext = word_t'(signed'(divisor));
    assign dvd_abs = WIDTH'(abs_val(dvd_ext));
    assign dsr_abs = WIDTH'(abs_val(dsr_ext));

    // dvd_q has become the quotient magnitude by FIX; on divide by zero it still holds |dividend|.
    assign rem_mag = zero_q ? dvd_q : rem_q;
    assign q_fix   = (dvd_neg_q ^ dsr_neg_q) ? WIDTH'(neg(word_t'(dvd_q))) : dvd_q;
    assign r_fix   = dvd_neg_q ? WIDTH'(neg(word_t'(rem_mag))) : rem_mag;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dsr_d     = dsr_q;
        rem_d     = rem_q;
        dvd_neg_d = dvd_neg_q;
        dsr_neg_d = dsr_neg_q;
        zero_d    = zero_q;
        busy_d    = busy;
        done_d    = 1'b0;
        quot_d    = quotient;
        remo_d    = remainder;
        dbz_d     = div_by_zero;

        case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d     = dvd_abs;
                    dsr_d     = dsr_abs;
                    rem_d     = '0;
                    dvd_neg_d = dividend[WIDTH-1];
                    dsr_neg_d = divisor[WIDTH-1];
                    zero_d    = (divisor == '0);
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = (divisor == '0) ? FIX : CALC;
                end
            end
            CALC: begin
                rem_d = step_rem;
                dvd_d = {dvd_q[WIDTH-2:0], step_q};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quot_d  = zero_q ? '1 : q_fix;
                remo_d  = r_fix;
                dbz_d   = zero_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            rem_q       <= '0;
            dvd_neg_q   <= 1'b0;
            dsr_neg_q   <= 1'b0;
            zero_q      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dsr_q       <= dsr_d;
            rem_q       <= rem_d;
            dvd_neg_q   <= dvd_neg_d;
            dsr_neg_q   <= dsr_neg_d;
            zero_q      <= zero_d;
            busy        <= busy_d;
            done        <= done_d;
            quotient    <= quot_d;
            remainder   <= remo_d;
            div_by_zero <= dbz_d;
        end
    end

endmodule
